// File: rtl/pid_pkg.sv
// Shared definitions for the PID multiply scheduler: default sizing, FSM states, clamp bounds.
package pid_pkg;

  localparam int W_DEF       = 6;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_P,
    WAIT_P,
    ISSUE_I,
    WAIT_I,
    ISSUE_D,
    WAIT_D,
    SUM
  } state_t;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pid_mul_scheduler_if.sv
// Request, multiplier and result signals of the PID scheduler.
interface pid_mul_scheduler_if
  import pid_pkg::*;
#(
  parameter int W = W_DEF
);
  logic                start;
  logic signed [W-1:0] error;
  logic        [W-1:0] kp;
  logic        [W-1:0] ki;
  logic        [W-1:0] kd;
  logic signed [W-1:0] mul_a;
  logic        [W-1:0] mul_b;
  logic                mul_start;
  logic                mul_done;
  logic signed [W-1:0] mul_product;
  logic signed [W-1:0] control;
  logic                valid;
  logic                busy;
  logic                timeout;

  modport slave (
    input  start, error, kp, ki, kd, mul_done, mul_product,
    output mul_a, mul_b, mul_start, control, valid, busy, timeout
  );

  modport master (
    output start, error, kp, ki, kd, mul_done, mul_product,
    input  mul_a, mul_b, mul_start, control, valid, busy, timeout
  );
endinterface

// File: rtl/pid_sat_add.sv
// Combinational a +/- b + c at W+2 bits, clamped to the signed W-bit range.
module pid_sat_add
  import pid_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  input  logic                sub_i,
  output logic signed [W-1:0] y_o
);
  localparam logic signed [W+1:0] HI_X = (W + 2)'(sat_hi(W));
  localparam logic signed [W+1:0] LO_X = (W + 2)'(sat_lo(W));

  logic signed [W+1:0] a_x, b_x, c_x, sum;

  always_comb begin
    a_x = {{2{a_i[W-1]}}, a_i};
    b_x = {{2{b_i[W-1]}}, b_i};
    c_x = {{2{c_i[W-1]}}, c_i};
    if (sub_i) begin
      b_x = -b_x;
    end
    sum = a_x + b_x + c_x;
    if (sum > HI_X) begin
      y_o = HI_X[W-1:0];
    end else if (sum < LO_X) begin
      y_o = LO_X[W-1:0];
    end else begin
      y_o = sum[W-1:0];
    end
  end
endmodule

// File: rtl/pid_mul_scheduler.sv
// Sequences P, I and D multiplies through one shared multiplier and emits a saturated sum.
// Latency 4 cycles plus the three multiply waits; ena low freezes everything.
module pid_mul_scheduler
  import pid_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  pid_mul_scheduler_if.slave bus
);
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t              state_q, state_d;
  logic signed [W-1:0] err_q, err_d, integ_q, integ_d, prev_q, prev_d;
  logic signed [W-1:0] tp_q, tp_d, ti_q, ti_d, td_q, td_d;
  logic signed [W-1:0] mul_a_q, mul_a_d, control_q, control_d;
  logic        [W-1:0] ki_q, ki_d, kd_q, kd_d, mul_b_q, mul_b_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d, timeout_q, timeout_d;

  logic signed [W-1:0] integ_sum, diff, total, wait_term;
  logic                in_wait, wait_over, wait_tmo;

  pid_sat_add #(.W(W)) u_integ (.a_i(integ_q), .b_i(err_q), .c_i('0), .sub_i(1'b0), .y_o(integ_sum));
  pid_sat_add #(.W(W)) u_diff  (.a_i(err_q), .b_i(prev_q), .c_i('0), .sub_i(1'b1), .y_o(diff));
  pid_sat_add #(.W(W)) u_sum   (.a_i(tp_q), .b_i(ti_q), .c_i(td_q), .sub_i(1'b0), .y_o(total));

  // A done pulse landing on the last permitted cycle wins over the timeout.
  assign in_wait   = (state_q == WAIT_P) || (state_q == WAIT_I) || (state_q == WAIT_D);
  assign wait_over = bus.mul_done || (cnt_q == CNT_MAX);
  assign wait_tmo  = !bus.mul_done && (cnt_q == CNT_MAX);
  assign wait_term = bus.mul_done ? bus.mul_product : '0;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ki_d      = ki_q;
    kd_d      = kd_q;
    integ_d   = integ_q;
    prev_d    = prev_q;
    tp_d      = tp_q;
    ti_d      = ti_q;
    td_d      = td_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    cnt_d     = cnt_q;
    control_d = control_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;

    if (in_wait && wait_tmo) begin
      timeout_d = 1'b1;
    end
    if (in_wait && !wait_over) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d   = bus.error;
          ki_d    = bus.ki;
          kd_d    = bus.kd;
          mul_a_d = bus.error;
          mul_b_d = bus.kp;
          state_d = ISSUE_P;
        end
      end
      ISSUE_P, ISSUE_I, ISSUE_D: begin
        cnt_d   = '0;
        state_d = (state_q == ISSUE_P) ? WAIT_P : (state_q == ISSUE_I) ? WAIT_I : WAIT_D;
      end
      WAIT_P: begin
        if (wait_over) begin
          tp_d    = wait_term;
          integ_d = integ_sum;
          mul_a_d = integ_sum;
          mul_b_d = ki_q;
          state_d = ISSUE_I;
        end
      end
      WAIT_I: begin
        if (wait_over) begin
          ti_d    = wait_term;
          mul_a_d = diff;
          mul_b_d = kd_q;
          state_d = ISSUE_D;
        end
      end
      WAIT_D: begin
        if (wait_over) begin
          td_d    = wait_term;
          state_d = SUM;
        end
      end
      SUM: begin
        control_d = total;
        prev_d    = err_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      integ_q   <= '0;
      prev_q    <= '0;
      tp_q      <= '0;
      ti_q      <= '0;
      td_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      cnt_q     <= '0;
      control_q <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      err_q     <= err_d;
      ki_q      <= ki_d;
      kd_q      <= kd_d;
      integ_q   <= integ_d;
      prev_q    <= prev_d;
      tp_q      <= tp_d;
      ti_q      <= ti_d;
      td_q      <= td_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      cnt_q     <= cnt_d;
      control_q <= control_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_start = ena && ((state_q == ISSUE_P) || (state_q == ISSUE_I) || (state_q == ISSUE_D));
  assign bus.control   = control_q;
  assign bus.valid     = valid_q && ena;
  assign bus.busy      = (state_q != IDLE);
  assign bus.timeout   = timeout_q;
endmodule

// File: doc/pid_mul_scheduler.md
PID_MUL_SCHEDULER -- requirements
Module: pid_mul_scheduler

Interface
REQ-001 SHALL have parameter W, default 6, signed datapath width for error, terms and control.
REQ-002 SHALL have parameter TIMEOUT, default 63, maximum cycles to wait for mul_done.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ena  input  1  global enable; low freezes all state.
REQ-006 start  input  1  one-cycle request to compute a new control sample.
REQ-007 error  input  W  signed error sample, captured on accepted start.
REQ-008 kp, ki, kd  input  W each  unsigned gain constants, captured on accepted start.
REQ-009 mul_a  output  W  signed multiplicand to the shared repeated-adder multiplier.
REQ-010 mul_b  output  W  unsigned multiplier constant to the multiplier.
REQ-011 mul_start  output  1  one-cycle launch pulse to the multiplier.
REQ-012 mul_done  input  1  multiplier completion pulse.
REQ-013 mul_product  input  W  signed, already-clipped product, valid with mul_done.
REQ-014 control  output  W  signed saturated P+I+D result, held until the next valid.
REQ-015 valid  output  1  one-cycle pulse when control updates.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout  output  1  sticky flag, set when any multiply exceeds TIMEOUT cycles.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE_P, WAIT_P, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D, SUM.
REQ-019 IDLE -> ISSUE_P on start&ena, capturing error and gains; start when not IDLE is ignored.
REQ-020 Each ISSUE_x SHALL drive mul_a/mul_b, pulse mul_start for exactly one cycle, clear the wait counter and advance to WAIT_x.
REQ-021 P term operands: mul_a=error, mul_b=kp.
REQ-022 On entering ISSUE_I, integ SHALL become sat(integ+error); operands mul_a=integ (updated value), mul_b=ki.
REQ-023 D term operands: mul_a=sat(error-prev_err), mul_b=kd; prev_err SHALL become error in SUM.
REQ-024 WAIT_x SHALL latch mul_product into term_x on mul_done and advance; mul_done in any other state is ignored.
REQ-025 WAIT_x SHALL count cycles; at count==TIMEOUT without mul_done, term_x=0, timeout=1, advance.
REQ-026 mul_done in the same cycle as the timeout condition SHALL take priority (product latched, no timeout).
REQ-027 SUM SHALL add the three terms at W+2 bits, saturate to [-2^(W-1), 2^(W-1)-1], load control, pulse valid, return to IDLE.
REQ-028 sat() SHALL clamp every W+1-bit intermediate to the signed W-bit range; no wrap-around anywhere.
REQ-029 Latency from accepted start to valid SHALL be 4 + sum of the three multiply wait durations.
REQ-030 ena low SHALL hold state, counters, registers and outputs; mul_start and valid SHALL be 0 while ena is low.
REQ-031 mul_a/mul_b SHALL hold their values from ISSUE_x through WAIT_x.

Reset
REQ-032 rst SHALL force state IDLE, and control, valid, busy, timeout, mul_start, mul_a, mul_b, integ, prev_err, terms and counters to 0.
REQ-033 rst asserted mid-operation SHALL abandon the sample with no valid pulse; a mul_done arriving after release is ignored.

Structure
REQ-034 A shared package pid_pkg SHALL hold W, TIMEOUT defaults, the FSM state enum, and the saturation bounds.
REQ-035 One sub-module, pid_sat_add (signed add/subtract with clamp to W bits), SHALL be instantiated for integ, diff and the final sum.

Verification (bench includes a multiplier model: product = clip(a*b), mul_done after b+1 cycles)
REQ-036 Reset: assert rst during WAIT_I -> all outputs 0 next cycle, busy=0, later sample starts from integ=0.
REQ-037 From reset, error=3, kp=2, ki=1, kd=1 -> terms 6,3,3, control=12, valid for one cycle, busy low after.
REQ-038 Follow-up error=-4, same gains -> integ=-1, diff=-7, terms -8,-1,-7, control=-16.
REQ-039 From reset, error=20, kp=ki=kd=1 -> terms 20,20,20, control=31 (saturated).
REQ-040 Multiplier model withholds mul_done for the D term -> after 63 wait cycles term_d=0, timeout=1 and stays 1, valid still pulses.
REQ-041 start pulsed while busy, and ena low for 10 cycles mid-WAIT_P -> extra start ignored, latency extends by exactly 10 cycles, single valid.
